// File: rtl/ifetch_queue.sv
// Instruction fetch sequencer feeding a DEPTH-entry prefetch queue; head is valid one cycle after push, a full queue without a pop stalls fetch_pc.
// Define IFETCH_MISALIGN_TRAP_EN to make a misaligned redirect set a sticky misalign_err and halt fetch until reset.
module ifetch_queue #(
   parameter int unsigned           DATA_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned           DEPTH      = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  fetch_en,
   output logic [DATA_WIDTH-1:0] imem_addr,
   input  logic [DATA_WIDTH-1:0] imem_data,
   input  logic                  redirect_valid,
   input  logic [DATA_WIDTH-1:0] redirect_pc,
   output logic                  instr_valid,
   input  logic                  instr_ready,
   output logic [DATA_WIDTH-1:0] instr_data,
   output logic [DATA_WIDTH-1:0] instr_pc,
   output logic                  misalign_err
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0]      FULL_CNT   = CNT_W'(DEPTH);
   localparam logic [DATA_WIDTH-1:0] PC_STEP    = DATA_WIDTH'(4);
   localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = ~(DATA_WIDTH'(3));

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] RUN    = 2'd1;
   localparam logic [1:0] BUBBLE = 2'd2;

   typedef struct packed {
      logic [DATA_WIDTH-1:0] pc;
      logic [DATA_WIDTH-1:0] dat;
   } entry_t;

   logic [1:0]            state_q, state_d;
   logic [DATA_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   entry_t                mem_q [DEPTH];
   entry_t                mem_d [DEPTH];

   logic redir;
   logic push;
   logic pop;
   logic trapped;
   logic trap_set;

`ifdef IFETCH_MISALIGN_TRAP_EN
   logic misalign_err_q, misalign_err_d;

   // Once trapped, further redirects are ignored so the error state cannot be escaped.
   assign trapped  = misalign_err_q;
   assign trap_set = redirect_valid && !misalign_err_q && (redirect_pc[1:0] != 2'b00);

   always_comb begin
      misalign_err_d = misalign_err_q | trap_set;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         misalign_err_q <= 1'b0;
      end else begin
         misalign_err_q <= misalign_err_d;
      end
   end

   assign misalign_err = misalign_err_q;
`else
   assign trapped      = 1'b0;
   assign trap_set     = 1'b0;
   assign misalign_err = 1'b0;
`endif

   assign redir = redirect_valid && !trapped;
   assign pop   = (count_q != '0) && instr_ready;
   assign push  = (state_q == RUN) && fetch_en && !redir && ((count_q != FULL_CNT) || pop);

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (fetch_en) state_d = RUN;
         RUN: begin
            if (!fetch_en)  state_d = IDLE;
            else if (redir) state_d = BUBBLE;
         end
         BUBBLE:  state_d = !fetch_en ? IDLE : (redir ? BUBBLE : RUN);
         default: state_d = IDLE;
      endcase
      if (trapped || trap_set) state_d = IDLE;
   end

   // A redirect wins over push and pop: the head accepted this cycle is simply dropped with the rest.
   always_comb begin
      fetch_pc_d = fetch_pc_q;
      count_d    = count_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      mem_d      = mem_q;
      if (redir) begin
         fetch_pc_d = redirect_pc & ALIGN_MASK;
         count_d    = '0;
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
      end else begin
         if (push) begin
            mem_d[wr_ptr_q].pc  = fetch_pc_q;
            mem_d[wr_ptr_q].dat = imem_data;
            wr_ptr_d            = wr_ptr_q + PTR_W'(1);
            fetch_pc_d          = fetch_pc_q + PC_STEP;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         count_d = count_q + CNT_W'(push) - CNT_W'(pop);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         fetch_pc_q <= RESET_PC & ALIGN_MASK;
         count_q    <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         mem_q      <= '{default: '0};
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         count_q    <= count_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         mem_q      <= mem_d;
      end
   end

   assign imem_addr   = fetch_pc_q;
   assign instr_valid = (count_q != '0);
   assign instr_pc    = mem_q[rd_ptr_q].pc;
   assign instr_data  = mem_q[rd_ptr_q].dat;

endmodule
